arb3_rr: RTL and testbench
==========================

# arb3_rr

Three-requester round-robin arbiter with a bounded hold time and a mandatory dead cycle between owners. It shares one resource, such as the memory/register bus driven through NOR3-based wired-select logic, between three masters. Typical masters are instruction fetch, load/store and the debug port. The dead cycle guarantees that two bus drivers are never enabled together, which matters for discrete-transistor drivers with slow turn-off.

## Interface

Parameters:
- `CNT_W`, default 4: width of the hold counter.
- `HOLD_MAX`, default 15: maximum grant length in cycles. Legal range is 1 .. 2^CNT_W−1.

Ports:
- `CLK`, input, 1: single clock. All state updates on the rising edge.
- `RST`, input, 1: synchronous reset, active-high.
- `REQ`, input, 3: request per master. Bit i belongs to master i.
- `DONE`, input, 1: current owner finished. Sampled only while a grant is active.
- `GNT`, output, 3: registered grant. One-hot or 000.
- `OWNER`, output, 2: encoded index of the current owner. 3 means no owner.
- `BUSY`, output, 1: 1 while `GNT` is non-zero.
- `TMO`, output, 1: one-cycle pulse marking a forced release.

## Operation

- **State register:** IDLE, GRANT, GAP.
- **Other registered state:**
  - Priority pointer `PTR` in {0,1,2}.
  - Hold counter `cnt`, CNT_W bits.
  - Current owner index.
- **Reset:** state=IDLE, `PTR`=0, `cnt`=0, `GNT`=000, `OWNER`=3, `BUSY`=0, `TMO`=0.
- **Search order:** `PTR`, `PTR`+1, `PTR`+2 (mod 3). The first set bit of `REQ` wins.
- **IDLE:**
  - `GNT`=000.
  - If `REQ`≠000, load the owner by the search order, set `cnt`=1, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT:**
  - `GNT` is one-hot on the owner, `OWNER`=owner, `BUSY`=1.
  - Each edge evaluates the exit conditions in this priority order:
    - a. `DONE`=1 → release, `TMO`=0.
    - b. `REQ[owner]`=0 → release, `TMO`=0.
    - c. `cnt`==`HOLD_MAX` → forced release, `TMO`=1.
    - d. Otherwise `cnt`=`cnt`+1 and stay in GRANT.
  - On any release: go to GAP and set `PTR`=(owner+1) mod 3. A timed-out owner loses priority exactly like a normal release.
- **GAP:**
  - Exactly one cycle. `GNT`=000, `OWNER`=3, `BUSY`=0.
  - `TMO` holds the value set on entry. `TMO` is 0 in every other cycle.
  - At the next edge, arbitrate as in IDLE using the updated `PTR`: go to GRANT if any request is present, otherwise go to IDLE.
- **Input handling:**
  - `REQ` changes during GRANT for non-owners are ignored until the next arbitration.
  - `DONE` is ignored in IDLE and GAP.
  - `REQ` is sampled only at arbitration edges (IDLE/GAP → GRANT). A request that rises and falls entirely within a single GRANT or GAP cycle, without being present at an arbitration edge, is lost.
- **Arithmetic:** `cnt` never exceeds `HOLD_MAX`, so it cannot wrap. `PTR` increments mod 3; the value 3 is never stored.
- **HOLD_MAX=1:** every grant lasts exactly one cycle and times out unless `DONE` is asserted or the owner's request drops.

## Timing

- **Grant latency from IDLE:** `REQ` asserted before edge n → `GNT` valid after edge n, in cycle n+1.
- **Release:** `DONE` (or the owner's `REQ` drop) sampled at edge m → `GNT`=000 in cycle m+1 (GAP).
- **Next owner:** the earliest next grant is in cycle m+2. `GNT` is never high in two consecutive cycles for different owners.
- **Maximum grant length:** `HOLD_MAX` consecutive cycles.
- **Worst-case wait:** a requester that holds `REQ` waits at most 2·(`HOLD_MAX`+1) cycles before its grant.
- **Simultaneous events:**
  - `DONE` and timeout on the same edge: `DONE` wins, `TMO`=0.
  - `RST` with anything: `RST` wins.
- **Reset mid-grant:** `RST` high at edge k forces the following outputs in cycle k+1, with no GAP cycle:
  - `GNT`=000.
  - `OWNER`=3.
  - `BUSY`=0.
  - `TMO`=0.

  The first grant after reset uses `PTR`=0.
- **Output source:** all outputs come directly from registers. There is no combinational path from `REQ` or `DONE` to `GNT`.

## Test plan

- **Reset:** `RST`=1 for 2 cycles with `REQ`=111. Required:
  - While `RST` is high: `GNT`=000, `OWNER`=3, `BUSY`=0, `TMO`=0.
  - Cycle after `RST` falls: `GNT`=001.
- **Single requester:** `REQ`=010 at edge 0. Required:
  - `GNT`=010 and `OWNER`=1 from cycle 1.
  - `DONE`=1 at edge 3 → `GNT`=000 in cycle 4.
  - Still `REQ`=010 → `GNT`=010 in cycle 5.
- **Round-robin:** `REQ`=111 held, with `DONE`=1 in every GRANT cycle. Required `GNT` sequence: 001, 000, 010, 000, 100, 000, 001, ...
- **Timeout:** `HOLD_MAX`=15, `REQ`=001 held, `DONE`=0. Required:
  - `GNT`=001 for exactly 15 cycles.
  - Then one GAP cycle with `GNT`=000 and `TMO`=1.
  - Then `GNT`=001 again.
  - With `REQ`=011 instead, the grant after the GAP goes to 010.
- **Coincident DONE/timeout:** `DONE`=1 on the 15th grant cycle. Required: GAP cycle has `TMO`=0.
- **Reset mid-grant and request drop:**
  - `RST` in grant cycle 3 of owner 2. Required: `GNT`=000 next cycle; with `REQ`=111, the next grant is 001.
  - Separately, owner 0 drops `REQ` in grant cycle 2 with no `DONE`. Required: GAP follows, `TMO`=0, and with `REQ`=111 the next grant is 010.

Source files
------------

// File: rtl/arb3_rr.sv
// Three-master round-robin arbiter with a bounded hold time.
// A mandatory one-cycle dead gap separates successive owners so two bus drivers are never enabled together.
module arb3_rr #(
  parameter int CNT_W    = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] REQ,
  input  logic       DONE,
  output logic [2:0] GNT,
  output logic [1:0] OWNER,
  output logic       BUSY,
  output logic       TMO
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MAX);

  state_t           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       own_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       gnt_q;
  logic [1:0]       owner_q;
  logic             busy_q;
  logic             tmo_q;

  logic             nxt_vld_d;
  logic [1:0]       nxt_own_d;
  logic [1:0]       cand;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Search PTR, PTR+1, PTR+2 (mod 3); first asserted request wins.
  always_comb begin
    nxt_vld_d = 1'b0;
    nxt_own_d = '0;
    cand      = ptr_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (!nxt_vld_d && REQ[cand]) begin
        nxt_vld_d = 1'b1;
        nxt_own_d = cand;
      end
      cand = inc3(cand);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      owner_q <= 2'd3;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      case (state_q)
        S_GRANT: begin
          if (DONE || !REQ[own_q] || cnt_q == HOLD_C) begin
            state_q <= S_GAP;
            ptr_q   <= inc3(own_q);
            gnt_q   <= '0;
            owner_q <= 2'd3;
            busy_q  <= 1'b0;
            // Timeout is flagged only when neither DONE nor a request drop caused the release.
            tmo_q   <= !DONE && REQ[own_q];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          tmo_q <= 1'b0;
          if (nxt_vld_d) begin
            state_q <= S_GRANT;
            own_q   <= nxt_own_d;
            cnt_q   <= CNT_W'(1);
            gnt_q   <= 3'b001 << nxt_own_d;
            owner_q <= nxt_own_d;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            owner_q <= 2'd3;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign GNT   = gnt_q;
  assign OWNER = owner_q;
  assign BUSY  = busy_q;
  assign TMO   = tmo_q;

endmodule

// File: tb/tb_arb3_rr.sv
// Self-checking bench for arb3_rr: directed scenarios plus randomized traffic
// against a behavioural model, run on a HOLD_MAX=15 and a HOLD_MAX=1 instance.
module tb_arb3_rr;

  logic       CLK;
  logic       RST;
  logic [2:0] REQ;
  logic       DONE;
  logic [2:0] gnt   [2];
  logic [1:0] owner [2];
  logic       busy  [2];
  logic       tmo   [2];

  int vectors;
  int miscompares;

  arb3_rr #(.CNT_W(4), .HOLD_MAX(15)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DONE(DONE),
    .GNT(gnt[0]), .OWNER(owner[0]), .BUSY(busy[0]), .TMO(tmo[0])
  );

  arb3_rr #(.CNT_W(4), .HOLD_MAX(1)) dut1 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DONE(DONE),
    .GNT(gnt[1]), .OWNER(owner[1]), .BUSY(busy[1]), .TMO(tmo[1])
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural model: owner index (-1 = nobody), cycles held, priority pointer, timeout flag.
  int m_owner [2];
  int m_len   [2];
  int m_ptr   [2];
  bit m_tmo   [2];
  int m_hold  [2];

  task automatic model_step(input int d);
    if (RST) begin
      m_owner[d] = -1; m_len[d] = 0; m_ptr[d] = 0; m_tmo[d] = 1'b0;
    end else if (m_owner[d] >= 0) begin
      if (DONE || !REQ[m_owner[d]] || m_len[d] == m_hold[d]) begin
        m_tmo[d]   = !(DONE || !REQ[m_owner[d]]);
        m_ptr[d]   = (m_owner[d] + 1) % 3;
        m_owner[d] = -1;
      end else begin
        m_len[d] = m_len[d] + 1;
      end
    end else begin
      m_tmo[d] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (m_ptr[d] + k) % 3;
        if (m_owner[d] < 0 && REQ[c]) begin
          m_owner[d] = c;
          m_len[d]   = 1;
        end
      end
    end
  endtask

  function automatic logic [2:0] exp_gnt(input int d);
    return (m_owner[d] < 0) ? 3'b000 : 3'(1 << m_owner[d]);
  endfunction

  function automatic logic [1:0] exp_owner(input int d);
    return (m_owner[d] < 0) ? 2'd3 : 2'(m_owner[d]);
  endfunction

  // Advance one clock: update the model from the inputs the DUT samples, then settle past the edge.
  task automatic tick();
    for (int d = 0; d < 2; d++) model_step(d);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ = 3'b000; DONE = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ = 3'b111; DONE = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (gnt[0] !== 3'b000 || owner[0] !== 2'd3 || busy[0] !== 1'b0 || tmo[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got gnt=%b owner=%0d busy=%b tmo=%b, want 000/3/0/0",
                 i, gnt[0], owner[0], busy[0], tmo[0]);
      end
    end
    RST = 1'b0;
    tick();
    vectors++;
    if (gnt[0] !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_first_grant: got %b want 001", gnt[0]);
    end
  endtask

  task automatic test_single();
    do_reset();
    REQ = 3'b010;
    for (int c = 1; c <= 3; c++) begin
      tick();
      vectors++;
      if (gnt[0] !== 3'b010 || owner[0] !== 2'd1 || busy[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL single_grant cycle %0d: got gnt=%b owner=%0d busy=%b want 010/1/1", c, gnt[0], owner[0], busy[0]);
      end
    end
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    vectors++;
    if (gnt[0] !== 3'b000 || tmo[0] !== 1'b0 || owner[0] !== 2'd3) begin
      miscompares++;
      $display("FAIL single_release: got gnt=%b tmo=%b owner=%0d want 000/0/3", gnt[0], tmo[0], owner[0]);
    end
    tick();
    vectors++;
    if (gnt[0] !== 3'b010) begin
      miscompares++;
      $display("FAIL single_regrant: got %b want 010", gnt[0]);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] seq [9];
    seq = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b010};
    do_reset();
    REQ = 3'b111; DONE = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      vectors++;
      if (gnt[0] !== seq[i]) begin
        miscompares++;
        $display("FAIL round_robin step %0d: got %b want %b", i, gnt[0], seq[i]);
      end
    end
    DONE = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    REQ = 3'b001;
    for (int c = 1; c <= 15; c++) begin
      tick();
      vectors++;
      if (gnt[0] !== 3'b001 || tmo[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_hold cycle %0d: got gnt=%b tmo=%b want 001/0", c, gnt[0], tmo[0]);
      end
    end
    tick();
    vectors++;
    if (gnt[0] !== 3'b000 || tmo[0] !== 1'b1 || busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_gap: got gnt=%b tmo=%b busy=%b want 000/1/0", gnt[0], tmo[0], busy[0]);
    end
    tick();
    vectors++;
    if (gnt[0] !== 3'b001 || tmo[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_regrant: got gnt=%b tmo=%b want 001/0", gnt[0], tmo[0]);
    end
    REQ = 3'b011;
    for (int c = 2; c <= 15; c++) tick();
    tick();
    vectors++;
    if (tmo[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_gap2: got tmo=%b want 1", tmo[0]);
    end
    tick();
    vectors++;
    if (gnt[0] !== 3'b010) begin
      miscompares++;
      $display("FAIL timeout_rotate: got %b want 010", gnt[0]);
    end
  endtask

  task automatic test_coincident();
    do_reset();
    REQ = 3'b001;
    for (int c = 1; c <= 15; c++) tick();
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    vectors++;
    if (gnt[0] !== 3'b000 || tmo[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL coincident_done: got gnt=%b tmo=%b want 000/0", gnt[0], tmo[0]);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    REQ = 3'b100;
    for (int c = 1; c <= 3; c++) tick();
    vectors++;
    if (gnt[0] !== 3'b100) begin
      miscompares++;
      $display("FAIL midrst_owner2: got %b want 100", gnt[0]);
    end
    RST = 1'b1; REQ = 3'b111;
    tick();
    vectors++;
    if (gnt[0] !== 3'b000 || owner[0] !== 2'd3 || busy[0] !== 1'b0 || tmo[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_clear: got gnt=%b owner=%0d busy=%b tmo=%b want 000/3/0/0", gnt[0], owner[0], busy[0], tmo[0]);
    end
    RST = 1'b0;
    tick();
    vectors++;
    if (gnt[0] !== 3'b001) begin
      miscompares++;
      $display("FAIL midrst_regrant: got %b want 001", gnt[0]);
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    REQ = 3'b111;
    tick();
    tick();
    REQ = 3'b110;
    tick();
    vectors++;
    if (gnt[0] !== 3'b000 || tmo[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_gap: got gnt=%b tmo=%b want 000/0", gnt[0], tmo[0]);
    end
    REQ = 3'b111;
    tick();
    vectors++;
    if (gnt[0] !== 3'b010) begin
      miscompares++;
      $display("FAIL drop_next: got %b want 010", gnt[0]);
    end
  endtask

  task automatic test_hold_one();
    do_reset();
    REQ = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (gnt[1] !== 3'b001 || tmo[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL hold1_grant round %0d: got gnt=%b tmo=%b want 001/0", i, gnt[1], tmo[1]);
      end
      tick();
      vectors++;
      if (gnt[1] !== 3'b000 || tmo[1] !== 1'b1) begin
        miscompares++;
        $display("FAIL hold1_gap round %0d: got gnt=%b tmo=%b want 000/1", i, gnt[1], tmo[1]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) REQ = 3'($urandom_range(0, 7));
      DONE = ($urandom_range(0, 9) == 0);
      RST  = ($urandom_range(0, 249) == 0);
      tick();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (gnt[d] !== exp_gnt(d) || owner[d] !== exp_owner(d) ||
            busy[d] !== (m_owner[d] >= 0) || tmo[d] !== m_tmo[d]) begin
          miscompares++;
          $display("FAIL random dut%0d step %0d: got gnt=%b owner=%0d busy=%b tmo=%b want %b/%0d/%b/%b",
                   d, n, gnt[d], owner[d], busy[d], tmo[d], exp_gnt(d), exp_owner(d), (m_owner[d] >= 0), m_tmo[d]);
        end
      end
    end
    RST = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m_hold[0] = 15;
    m_hold[1] = 1;
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_len[d] = 0; m_ptr[d] = 0; m_tmo[d] = 1'b0;
    end
    RST = 1'b1; REQ = 3'b000; DONE = 1'b0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_coincident();
    test_reset_mid_grant();
    test_req_drop();
    test_hold_one();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
